// File: rtl/laser_pkg.sv
// Shared constants and types for the LASER target interface.
// The LASER core and the point feeder both use this package.
package laser_pkg;

    localparam int NUM_POINTS  = 40;
    localparam int COORD_W     = 4;
    localparam int RADIUS_SQ   = 16;
    localparam int TIMEOUT_CYC = 4096;
    localparam int IDX_W       = 6;
    localparam int WAIT_W      = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_FEED,
        ST_WAIT,
        ST_SCORE,
        ST_REPORT
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } point_t;

endpackage

// File: rtl/laser_circle_cover.sv
// Combinational coverage test: is point p within the radius of circle centre c?
// Uses unsigned absolute differences, so there is no sign handling.
module laser_circle_cover
    import laser_pkg::*;
(
    input  logic [3:0] cx,
    input  logic [3:0] cy,
    input  logic [3:0] px,
    input  logic [3:0] py,
    output logic       covered
);

    logic [COORD_W-1:0]   dx;
    logic [COORD_W-1:0]   dy;
    logic [2*COORD_W-1:0] dx_sq;
    logic [2*COORD_W-1:0] dy_sq;
    logic [2*COORD_W:0]   dist_sq;

    always_comb begin
        dx      = (cx >= px) ? (cx - px) : (px - cx);
        dy      = (cy >= py) ? (cy - py) : (py - cy);
        dx_sq   = (2*COORD_W)'(dx) * (2*COORD_W)'(dx);
        dy_sq   = (2*COORD_W)'(dy) * (2*COORD_W)'(dy);
        dist_sq = (2*COORD_W+1)'(dx_sq) + (2*COORD_W+1)'(dy_sq);
        covered = (dist_sq <= (2*COORD_W+1)'(RADIUS_SQ));
    end

endmodule

// File: rtl/laser_point_feeder.sv
// Drives a LASER core: streams 40 stored points, waits for its circle centres,
// then scores the centres by counting how many points the two circles cover.
module laser_point_feeder
    import laser_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       load_en,
    input  logic [5:0] load_idx,
    input  logic [3:0] load_x,
    input  logic [3:0] load_y,
    input  logic       start,
    output logic       busy,
    output logic       LRST,
    output logic [3:0] X,
    output logic [3:0] Y,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    input  logic       DONE,
    output logic [5:0] score,
    output logic       score_valid,
    output logic       timeout
);

    localparam logic [IDX_W-1:0]  NUM_IDX   = IDX_W'(NUM_POINTS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_POINTS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    state_t             state;
    state_t             state_nxt;
    point_t             mem [NUM_POINTS];
    point_t             cur_pt;
    point_t             xy_q;
    point_t             c1_q;
    point_t             c2_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [IDX_W-1:0]   acc_q;
    logic [IDX_W-1:0]   score_q;
    logic               timeout_q;
    logic               cov1;
    logic               cov2;
    logic               covered;

    always_ff @(posedge CLK) begin
        // NOTE: the point array has no reset: loaded points must survive RST, and an unreset array maps to plain storage.
        if (state == ST_IDLE && load_en && load_idx < NUM_IDX)
            mem[load_idx] <= {load_y, load_x};
    end

    // Single read port shared by FEED (one index ahead of X/Y) and SCORE.
    assign cur_pt = mem[idx_q];

    laser_circle_cover u_cover_c1 (
        .cx      (c1_q.x),
        .cy      (c1_q.y),
        .px      (cur_pt.x),
        .py      (cur_pt.y),
        .covered (cov1)
    );

    laser_circle_cover u_cover_c2 (
        .cx      (c2_q.x),
        .cy      (c2_q.y),
        .px      (cur_pt.x),
        .py      (cur_pt.y),
        .covered (cov2)
    );

    assign covered = cov1 | cov2;

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking so every register samples the pre-edge value of every other register.
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missed path would infer a latch.
        state_nxt   = state;
        busy        = (state != ST_IDLE);
        LRST        = 1'b0;
        score_valid = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_PULSE;
            ST_PULSE: begin
                LRST      = 1'b1;
                state_nxt = ST_FEED;
            end
            ST_FEED:   if (idx_q == NUM_IDX) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (DONE)                    state_nxt = ST_SCORE;
                else if (wait_q == WAIT_LAST) state_nxt = ST_REPORT;
            end
            ST_SCORE:  if (idx_q == LAST_IDX) state_nxt = ST_REPORT;
            ST_REPORT: begin
                score_valid = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            xy_q      <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            idx_q     <= '0;
            wait_q    <= '0;
            acc_q     <= '0;
            score_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx_q     <= '0;
                        score_q   <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    xy_q  <= cur_pt;
                    idx_q <= idx_q + IDX_W'(1);
                end
                ST_FEED: begin
                    wait_q <= '0;
                    if (idx_q == NUM_IDX) begin
                        xy_q  <= '0;
                        idx_q <= '0;
                    end else begin
                        xy_q  <= cur_pt;
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_WAIT: begin
                    wait_q <= wait_q + WAIT_W'(1);
                    if (DONE) begin
                        c1_q  <= {C1Y, C1X};
                        c2_q  <= {C2Y, C2X};
                        acc_q <= '0;
                    end else if (wait_q == WAIT_LAST) begin
                        score_q   <= '0;
                        timeout_q <= 1'b1;
                    end
                end
                ST_SCORE: begin
                    acc_q <= acc_q + IDX_W'(covered);
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX)
                        score_q <= acc_q + IDX_W'(covered);
                end
                default: ;
            endcase
        end
    end

    assign X       = xy_q.x;
    assign Y       = xy_q.y;
    assign score   = score_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_laser_point_feeder.sv
// Scoreboard bench for laser_point_feeder: the driver queues expected streams and
// scores, and a negedge monitor checks them whenever the DUT presents output.
module tb_laser_point_feeder;
    import laser_pkg::*;

    typedef struct packed {
        logic [5:0] sc;
        logic       to;
    } res_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       load_en;
    logic [5:0] load_idx;
    logic [3:0] load_x;
    logic [3:0] load_y;
    logic       start;
    logic       busy;
    logic       LRST;
    logic [3:0] X;
    logic [3:0] Y;
    logic [3:0] C1X, C1Y, C2X, C2Y;
    logic       DONE;
    logic [5:0] score;
    logic       score_valid;
    logic       timeout;

    int     total = 0;
    int     bad   = 0;
    point_t tb_mem [NUM_POINTS];
    point_t exp_pts [$];
    res_t   exp_res [$];
    int     stream_left = 0;
    bit     mon_en      = 1'b0;
    bit     prev_chk    = 1'b0;
    bit     prev_ok     = 1'b0;

    laser_point_feeder dut (
        .CLK         (CLK),
        .RST         (RST),
        .load_en     (load_en),
        .load_idx    (load_idx),
        .load_x      (load_x),
        .load_y      (load_y),
        .start       (start),
        .busy        (busy),
        .LRST        (LRST),
        .X           (X),
        .Y           (Y),
        .C1X         (C1X),
        .C1Y         (C1Y),
        .C2X         (C2X),
        .C2Y         (C2Y),
        .DONE        (DONE),
        .score       (score),
        .score_valid (score_valid),
        .timeout     (timeout)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_pt(input int i, input logic [3:0] x, input logic [3:0] y);
        load_en  = 1'b1;
        load_idx = 6'(i);
        load_x   = x;
        load_y   = y;
        tick();
        load_en  = 1'b0;
        if (i < NUM_POINTS) tb_mem[i] = {y, x};
    endtask

    // mode 0: normal; 1: DONE only during FEED (timeout); 2: start/load while busy; 3: RST mid-FEED
    task automatic run(input logic [3:0] c1x, input logic [3:0] c1y,
                       input logic [3:0] c2x, input logic [3:0] c2y,
                       input int exp_score, input logic exp_to, input int mode,
                       input bit ld, input int li, input logic [3:0] lx, input logic [3:0] ly);
        int n;
        C1X = c1x; C1Y = c1y; C2X = c2x; C2Y = c2y;
        if (ld) begin
            load_en  = 1'b1;
            load_idx = li[5:0];
            load_x   = lx;
            load_y   = ly;
            tb_mem[li] = {ly, lx};
        end
        for (int i = 0; i < NUM_POINTS; i++) exp_pts.push_back(tb_mem[i]);
        if (mode != 3) exp_res.push_back('{sc: exp_score[5:0], to: exp_to});
        start = 1'b1;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        // cycle t after start acceptance: t=1 is PULSE, t=2..41 is FEED
        for (int t = 1; t <= 41; t++) begin
            DONE = (mode == 1 && t == 11);
            if (mode == 2 && t == 6) begin
                start    = 1'b1;
                load_en  = 1'b1;
                load_idx = 6'd30;
                load_x   = 4'd0;
                load_y   = 4'd0;
            end else begin
                start   = 1'b0;
                load_en = 1'b0;
            end
            if (mode == 3 && t == 6) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
                check("rst_mid_busy", busy, 0);
                check("rst_mid_x", X, 0);
                check("rst_mid_y", Y, 0);
                check("rst_mid_valid", score_valid, 0);
                repeat (20) tick();
                return;
            end
            tick();
        end
        DONE = 1'b0; start = 1'b0; load_en = 1'b0;
        n = 0;
        if (mode != 1) begin
            repeat (3) tick();
            DONE = 1'b1;
            tick();
            DONE = 1'b0;
            C1X = 4'hA; C1Y = 4'hA; C2X = 4'hA; C2Y = 4'hA;
            while (!score_valid && n < 100) begin tick(); n++; end
            check("done_to_valid_cycles", n, NUM_POINTS);
        end else begin
            while (!score_valid && n < 5000) begin tick(); n++; end
            check("wait_to_timeout_cycles", n, TIMEOUT_CYC);
        end
        tick();
        check("busy_after_report", busy, 0);
        check("score_hold", score, exp_score);
        check("timeout_hold", timeout, exp_to);
    endtask

    always @(negedge CLK) begin
        point_t p;
        res_t   r;
        if (mon_en) begin
            if (prev_chk) check("lrst_after_start", LRST, prev_ok);
            prev_chk = start;
            prev_ok  = start && !busy && !RST;
            if (stream_left > 0) begin
                if (exp_pts.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stream_queue: got no expected point, required one queued");
                end else begin
                    p = exp_pts.pop_front();
                    check("stream_xy", {Y, X}, p);
                end
                stream_left--;
            end else begin
                check("xy_idle_zero", {Y, X}, 8'h00);
            end
            if (LRST) begin
                check("busy_in_pulse", busy, 1);
                stream_left = NUM_POINTS;
            end
            if (RST) begin
                stream_left = 0;
                exp_pts.delete();
            end
            if (score_valid) begin
                if (exp_res.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_score_valid: got score=%0d timeout=%0b, required no pulse", score, timeout);
                end else begin
                    r = exp_res.pop_front();
                    check("score", score, r.sc);
                    check("timeout", timeout, r.to);
                end
            end
        end
    end

    initial begin
        RST = 1'b1; load_en = 1'b0; load_idx = '0; load_x = '0; load_y = '0;
        start = 1'b0; DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_lrst", LRST, 0);
        check("reset_x", X, 0);
        check("reset_y", Y, 0);
        check("reset_score", score, 0);
        check("reset_score_valid", score_valid, 0);
        check("reset_timeout", timeout, 0);
        RST    = 1'b0;
        mon_en = 1'b1;
        tick();

        // all points at (5,5), C1 on top of them
        for (int i = 0; i < NUM_POINTS; i++) load_pt(i, 4'd5, 4'd5);
        run(4'd5, 4'd5, 4'd0, 4'd0, 40, 1'b0, 0, 1'b0, 0, 4'd0, 4'd0);

        // half at origin, half at far corner; point 0 written in the start cycle
        for (int i = 1; i < 20; i++) load_pt(i, 4'd0, 4'd0);
        for (int i = 20; i < NUM_POINTS; i++) load_pt(i, 4'd15, 4'd15);
        run(4'd0, 4'd0, 4'd0, 4'd0, 20, 1'b0, 0, 1'b1, 0, 4'd0, 4'd0);
        run(4'd0, 4'd0, 4'd15, 4'd15, 40, 1'b0, 0, 1'b0, 0, 4'd0, 4'd0);

        // radius boundary around the origin: first four covered, next four not
        load_pt(0, 4'd4, 4'd0);
        load_pt(1, 4'd0, 4'd4);
        load_pt(2, 4'd2, 4'd3);
        load_pt(3, 4'd3, 4'd2);
        load_pt(4, 4'd3, 4'd3);
        load_pt(5, 4'd4, 4'd1);
        load_pt(6, 4'd1, 4'd4);
        load_pt(7, 4'd5, 4'd0);
        for (int i = 8; i < NUM_POINTS; i++) load_pt(i, 4'd15, 4'd15);
        run(4'd0, 4'd0, 4'd0, 4'd0, 4, 1'b0, 0, 1'b0, 0, 4'd0, 4'd0);

        // DONE only during FEED: must time out with score 0
        run(4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b1, 1, 1'b0, 0, 4'd0, 4'd0);

        // start and load while busy are ignored
        run(4'd0, 4'd0, 4'd0, 4'd0, 4, 1'b0, 2, 1'b0, 0, 4'd0, 4'd0);

        // RST mid-FEED aborts; memory survives for the next run
        run(4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b0, 3, 1'b0, 0, 4'd0, 4'd0);
        run(4'd0, 4'd0, 4'd0, 4'd0, 4, 1'b0, 0, 1'b0, 0, 4'd0, 4'd0);

        repeat (5) tick();
        check("results_all_seen", exp_res.size(), 0);
        check("points_all_seen", exp_pts.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/laser_point_feeder.md
Name: laser_point_feeder

Overview:
- Driver and scorer for the far end of the LASER target interface.
- Holds 40 target points loaded by a host, streams them to the LASER core one per cycle over X/Y, then waits for DONE.
- Captures the two circle centres C1/C2 and scores them by counting the points covered by the union of both circles.
- Sits beside the LASER core in the integration top and acts as the self-checking source in system benches.

Parameters:
- NUM_POINTS, 40, number of target points streamed per run (fixed at the LASER core's capture depth).
- RADIUS_SQ, 16, squared coverage radius; a point is covered iff dx*dx + dy*dy <= RADIUS_SQ.
- TIMEOUT_CYC, 4096, maximum cycles spent in WAIT before the run is abandoned.

Ports:
- CLK, in, 1: clock.
- RST, in, 1: synchronous, active-high reset.
- load_en, in, 1: write one point into the point memory.
- load_idx, in, 6: point index, 0..NUM_POINTS-1.
- load_x, in, 4: point x coordinate.
- load_y, in, 4: point y coordinate.
- start, in, 1: begin a run (single-cycle pulse).
- busy, out, 1: high from the cycle after start is accepted until the cycle after score_valid.
- LRST, out, 1: one-cycle reset pulse to the LASER core.
- X, out, 4: point x coordinate streamed to the core.
- Y, out, 4: point y coordinate streamed to the core.
- C1X, in, 4: circle 1 centre x from the core.
- C1Y, in, 4: circle 1 centre y from the core.
- C2X, in, 4: circle 2 centre x from the core.
- C2Y, in, 4: circle 2 centre y from the core.
- DONE, in, 1: core result-valid strobe.
- score, out, 6: covered-point count, 0..40.
- score_valid, out, 1: one-cycle pulse; score and timeout are valid in this cycle.
- timeout, out, 1: run abandoned with no DONE; valid with score_valid.

Behaviour:
- Reset (synchronous, active-high on RST):
  - State is IDLE.
  - busy, LRST, X, Y, score, score_valid and timeout are all 0.
  - Point memory is NOT cleared.
  - RST mid-run aborts immediately; no score_valid is produced.
- Loading:
  - load_en writes mem[load_idx] = {load_y, load_x} in IDLE only.
  - load_en is ignored while busy; load_idx >= NUM_POINTS is ignored.
- FSM: IDLE -> PULSE -> FEED -> WAIT -> SCORE -> REPORT -> IDLE.
- IDLE:
  - start=1 moves to PULSE.
  - start in any other state is ignored.
- PULSE:
  - One cycle, LRST=1 and X=Y=0; moves to FEED.
- FEED:
  - Counter k runs 0..NUM_POINTS-1; X/Y = mem[k] registered, one point per cycle, no gaps.
  - Point 0 appears in the first cycle after LRST drops.
  - After k=NUM_POINTS-1, moves to WAIT; X/Y are then held at 0.
  - DONE during PULSE or FEED is ignored.
- WAIT:
  - On the first cycle with DONE=1, latch C1X/C1Y/C2X/C2Y and move to SCORE.
  - The wait counter counts from 0. If it reaches TIMEOUT_CYC-1 without DONE, move to REPORT with timeout=1 and score=0.
- SCORE:
  - Iterate j=0..NUM_POINTS-1, one point per cycle: NUM_POINTS cycles.
  - covered = in(C1, mem[j]) OR in(C2, mem[j]).
  - Accumulator is 6 bits; it cannot overflow since the maximum is 40.
  - A point covered by both circles counts once.
- Circle test in(c, p):
  - |dx| and |dy| are unsigned 4-bit absolute differences.
  - Squares are 8 bits; the sum is 9 bits; covered iff sum <= RADIUS_SQ.
  - Equivalent row table for |dx|=0..4, with covered |dy| in brackets: 0 [0..4], 1 [0..3], 2 [0..3], 3 [0..2], 4 [0].
- REPORT:
  - score_valid=1 for one cycle; score and timeout are valid.
  - score and timeout hold their values until the next run enters PULSE.
  - Next state IDLE; busy drops in the following cycle.
- Latency:
  - start accepted at edge E.
  - LRST is high in cycle E+1.
  - Points stream in E+2 .. E+41.
  - score_valid arrives NUM_POINTS+1 cycles after the DONE sample edge.
- start in the same cycle as RST: RST wins.
- start together with load_en in IDLE: the write lands first and the run uses the new value.

Decomposition:
- Package laser_pkg holds:
  - NUM_POINTS, RADIUS_SQ and the coordinate width 4;
  - the state enum;
  - point_t = {y[3:0], x[3:0]}.
- One sub-module: laser_circle_cover, a combinational in(c, p) test instantiated twice (C1, C2).
  - The LASER core can reuse the same sub-module.

Test Plan:
- Load all 40 points = (5,5); start; model replies DONE with C1=(5,5), C2=(0,0) -> X/Y stream (5,5) x40 starting 2 cycles after start; score=40, timeout=0.
- Points 0..19=(0,0), 20..39=(15,15); C1=(0,0), C2=(0,0) -> score=20; rerun with C2=(15,15) -> score=40.
- Boundary with C1=C2=(0,0):
  - points (4,0), (0,4), (2,3), (3,2) covered;
  - points (3,3), (4,1), (1,4), (5,0) not covered;
  - 32 filler points at (15,15) -> score=4.
- DONE pulsed during FEED, then never again -> no early capture; timeout=1, score=0 exactly TIMEOUT_CYC cycles after WAIT entry.
- start and load_en during busy -> ignored, so stream and memory are unchanged. RST asserted mid-FEED -> next cycle busy=0, X=Y=0, no score_valid. A subsequent run reuses the retained memory.
